// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared FP widths, special-value constants, FSM state and operand class types
package float_pkg;

   localparam int DEF_E = 8;
   localparam int DEF_M = 23;
   localparam int BIAS  = 2**(DEF_E-1) - 1;

   localparam logic [DEF_E+DEF_M:0] QNAN_Q = {1'b0, {DEF_E{1'b1}}, 1'b1, {(DEF_M-1){1'b0}}};
   localparam logic [DEF_E+DEF_M:0] INF_Q  = {1'b0, {DEF_E{1'b1}}, {DEF_M{1'b0}}};
   localparam logic [DEF_E+DEF_M:0] ZERO_Q = '0;

   typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
   typedef enum logic [1:0] {ZERO, NORMAL, INF} cls_t;

   // Denormals are flushed to zero; an all-ones exponent is infinity regardless of mantissa.
   function automatic cls_t classify(input logic exp_zero, input logic exp_ones);
      cls_t c;
      c = NORMAL;
      if (exp_zero)
         c = ZERO;
      else if (exp_ones)
         c = INF;
      return c;
   endfunction

endpackage

// File: rtl/float_div_normal.sv
// rtl/float_div_normal.sv - packs the raw quotient into a float, resolving specials and range limits
module float_div_normal
   import float_pkg::*;
#(
   parameter int E = DEF_E,
   parameter int M = DEF_M
) (
   input  logic [M+1:0] quo,
   input  logic [E+1:0] exp_diff,
   input  logic         sign,
   input  logic [1:0]   cls_a,
   input  logic [1:0]   cls_b,
   output logic [E+M:0] q,
   output logic         ovf,
   output logic         unf
);

   localparam logic signed [E+1:0] BIAS_X = (E+2)'(2**(E-1) - 1);
   localparam logic signed [E+1:0] EMAX_X = (E+2)'(2**E - 1);
   localparam logic signed [E+1:0] ONE_X  = (E+2)'(1);
   localparam logic signed [E+1:0] ZERO_X = '0;
   localparam logic [E-1:0]        EXP_ONES  = '1;
   localparam logic [M-1:0]        QNAN_MANT = {1'b1, {(M-1){1'b0}}};

   logic signed [E+1:0] exp_n;
   logic [M-1:0]        mant_n;

   always_comb begin
      // Quotient of two [1,2) mantissas lies in (0.5,2): at most one normalizing shift.
      if (quo[M+1]) begin
         mant_n = quo[M:1];
         exp_n  = $signed(exp_diff) + BIAS_X;
      end else begin
         mant_n = quo[M-1:0];
         exp_n  = $signed(exp_diff) + BIAS_X - ONE_X;
      end

      q   = {sign, exp_n[E-1:0], mant_n};
      ovf = 1'b0;
      unf = 1'b0;
      if ((cls_a == ZERO && cls_b == ZERO) || (cls_a == INF && cls_b == INF)) begin
         q = {1'b0, EXP_ONES, QNAN_MANT};
      end else if (cls_a == INF || cls_b == ZERO) begin
         q = {sign, EXP_ONES, {M{1'b0}}};
      end else if (cls_a == ZERO || cls_b == INF) begin
         q = {sign, {(E+M){1'b0}}};
      end else if (exp_n >= EMAX_X) begin
         q   = {sign, EXP_ONES, {M{1'b0}}};
         ovf = 1'b1;
      end else if (exp_n <= ZERO_X) begin
         q   = {sign, {(E+M){1'b0}}};
         unf = 1'b1;
      end
   end

endmodule

// File: rtl/float_div_seq.sv
// rtl/float_div_seq.sv - iterative restoring floating-point divider, one quotient bit per cycle
module float_div_seq
   import float_pkg::*;
#(
   parameter int E = DEF_E,
   parameter int M = DEF_M
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [E+M:0] a,
   input  logic [E+M:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [E+M:0] q,
   output logic         flag_dz,
   output logic         flag_ovf,
   output logic         flag_unf
);

   localparam int              CW       = $clog2(M+2);
   localparam logic [CW-1:0]   CNT_LOAD = CW'(M+1);

   state_t         state, state_nx;
   logic           sign_r;
   logic [E+1:0]   exp_diff;
   logic [1:0]     cls_a, cls_b;
   logic [M+1:0]   rem, quo, rem_sub;
   logic [M:0]     dvs;
   logic [CW-1:0]  cnt;
   logic           accept, ge;
   logic [E+M:0]   q_n;
   logic           ovf_n, unf_n;
   cls_t           cls_a_in, cls_b_in;

   assign accept   = in_valid & in_ready;
   assign cls_a_in = classify(a[E+M-1:M] == '0, &a[E+M-1:M]);
   assign cls_b_in = classify(b[E+M-1:M] == '0, &b[E+M-1:M]);
   assign ge       = rem >= {1'b0, dvs};
   assign rem_sub  = rem - {1'b0, dvs};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = DIV;
         DIV:     if (cnt == '0) state_nx = NORM;
         NORM:    state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Specials still run the full DIV sequence so latency never depends on data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_r   <= 1'b0;
         exp_diff <= '0;
         cls_a    <= '0;
         cls_b    <= '0;
         rem      <= '0;
         dvs      <= '0;
         quo      <= '0;
         cnt      <= '0;
         q        <= '0;
         flag_dz  <= 1'b0;
         flag_ovf <= 1'b0;
         flag_unf <= 1'b0;
      end else begin
         if (accept) begin
            sign_r   <= a[E+M] ^ b[E+M];
            exp_diff <= {2'b00, a[E+M-1:M]} - {2'b00, b[E+M-1:M]};
            cls_a    <= cls_a_in;
            cls_b    <= cls_b_in;
            rem      <= {2'b01, a[M-1:0]};
            dvs      <= {1'b1, b[M-1:0]};
            quo      <= '0;
            cnt      <= CNT_LOAD;
            flag_dz  <= 1'b0;
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
         end
         if (state == DIV) begin
            rem <= ge ? (rem_sub << 1) : (rem << 1);
            quo <= {quo[M:0], ge};
            cnt <= cnt - CW'(1);
         end
         if (state == NORM) begin
            q        <= q_n;
            flag_dz  <= (cls_a == NORMAL) && (cls_b == ZERO);
            flag_ovf <= ovf_n;
            flag_unf <= unf_n;
         end
      end
   end

   float_div_normal #(.E(E), .M(M)) u_normal (
      .quo      (quo),
      .exp_diff (exp_diff),
      .sign     (sign_r),
      .cls_a    (cls_a),
      .cls_b    (cls_b),
      .q        (q_n),
      .ovf      (ovf_n),
      .unf      (unf_n)
   );

endmodule
